fp_writeback_scheduler: RTL and testbench

//  Owns the single write port of the 32-entry FP register file and shares it between three FP result producers:
//  req0 = FLW load return, req1 = pipelined FPU (add/mul/fma/cvt), req2 = iterative div/sqrt.

---
 rtl/fp_writeback_scheduler.sv | 139 +++++++++++++
 tb/tb_fp_writeback_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_writeback_scheduler.sv
// Purpose: arbitrates three FP result producers onto the single FP register-file write port and tracks pending destinations.
// Latency: a producer transfer in cycle N appears as a register-file write in cycle N+1; its pending bit clears at the end of N+1.
// Backpressure: producers wait on a one-hot round-robin grant; issue is held off on RAW/WAW hazards and while draining.
module fp_writeback_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                          in_Clk,
    input  logic                          in_Rst_N,
    input  logic                          in_issue_Valid,
    input  logic [ADDR_WIDTH-1:0]         in_issue_Rd,
    input  logic [ADDR_WIDTH-1:0]         in_issue_Rs1,
    input  logic [ADDR_WIDTH-1:0]         in_issue_Rs2,
    input  logic [ADDR_WIDTH-1:0]         in_issue_Rs3,
    input  logic [2:0]                    in_issue_UseMask,
    output logic                          out_issue_Ready,
    input  logic                          in_flush,
    input  logic [2:0]                    in_req_Valid,
    input  logic [3*ADDR_WIDTH-1:0]       in_req_Addr,
    input  logic [3*DATA_WIDTH-1:0]       in_req_Data,
    output logic [2:0]                    out_req_Ready,
    output logic [DATA_WIDTH-1:0]         out_rf_Data,
    output logic [ADDR_WIDTH-1:0]         out_rf_writeAddr,
    output logic                          out_rf_write_En,
    output logic [(1<<ADDR_WIDTH)-1:0]    out_pending_Mask,
    output logic                          out_drain_Busy,
    output logic                          out_err_Stray
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;

    state_t                r_state;
    logic [NUM_REGS-1:0]   r_pending;
    logic [NUM_REGS-1:0]   w_pending_nxt;
    logic [1:0]            r_rr_ptr;
    logic [1:0]            w_grant_idx;
    logic [1:0]            w_cand;
    logic [1:0]            w_rr_nxt;
    logic [2:0]            w_sum;
    logic                  w_found;
    logic                  w_xfer;
    logic                  w_accept;
    logic                  w_src_hazard;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [ADDR_WIDTH-1:0] r_rf_addr;
    logic [DATA_WIDTH-1:0] r_rf_data;
    logic                  r_rf_we;
    logic                  r_err;

    // Issue gate: any used source or the destination still pending blocks issue; reset also forces it low.
    always_comb begin
        w_src_hazard = 1'b0;
        if (in_issue_UseMask[0] && r_pending[in_issue_Rs1]) w_src_hazard = 1'b1;
        if (in_issue_UseMask[1] && r_pending[in_issue_Rs2]) w_src_hazard = 1'b1;
        if (in_issue_UseMask[2] && r_pending[in_issue_Rs3]) w_src_hazard = 1'b1;
        out_issue_Ready = in_Rst_N && (r_state == ST_RUN) && !r_pending[in_issue_Rd] && !w_src_hazard;
        w_accept        = in_issue_Valid && out_issue_Ready;
    end

    // Round-robin search over the three producers starting at r_rr_ptr.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = r_rr_ptr;
        w_sum       = 3'd0;
        w_cand      = 2'd0;
        for (int k = 0; k < 3; k++) begin
            w_sum  = {1'b0, r_rr_ptr} + 3'(k);
            w_cand = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
            if (!w_found && in_req_Valid[w_cand]) begin
                w_found     = 1'b1;
                w_grant_idx = w_cand;
            end
        end
        w_xfer        = w_found && in_Rst_N;
        out_req_Ready = w_xfer ? (3'b001 << w_grant_idx) : 3'b000;
        w_rr_nxt      = (w_grant_idx == 2'd2) ? 2'd0 : w_grant_idx + 2'd1;
    end

    // Select the granted producer's destination and result.
    always_comb begin
        case (w_grant_idx)
            2'd1:    begin w_sel_addr = in_req_Addr[ADDR_WIDTH +: ADDR_WIDTH];   w_sel_data = in_req_Data[DATA_WIDTH +: DATA_WIDTH];   end
            2'd2:    begin w_sel_addr = in_req_Addr[2*ADDR_WIDTH +: ADDR_WIDTH]; w_sel_data = in_req_Data[2*DATA_WIDTH +: DATA_WIDTH]; end
            default: begin w_sel_addr = in_req_Addr[0 +: ADDR_WIDTH];            w_sel_data = in_req_Data[0 +: DATA_WIDTH];            end
        endcase
    end

    // Scoreboard update: the write in the output register clears its bit, a new issue sets its bit and wins on collision.
    always_comb begin
        w_pending_nxt = r_pending;
        if (r_rf_we)  w_pending_nxt[r_rf_addr]   = 1'b0;
        if (w_accept) w_pending_nxt[in_issue_Rd] = 1'b1;
    end

    // Write-port register, round-robin pointer, scoreboard and sticky stray-write flag.
    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            r_rf_we   <= 1'b0;
            r_rf_addr <= '0;
            r_rf_data <= '0;
            r_rr_ptr  <= 2'd0;
            r_pending <= '0;
            r_err     <= 1'b0;
        end else begin
            r_rf_we   <= w_xfer;
            r_pending <= w_pending_nxt;
            if (w_xfer) begin
                r_rf_addr <= w_sel_addr;
                r_rf_data <= w_sel_data;
                r_rr_ptr  <= w_rr_nxt;
                if (!r_pending[w_sel_addr]) r_err <= 1'b1;
            end
        end
    end

    // RUN/DRAIN control: leave DRAIN once nothing is pending, in the output register, or being granted.
    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            r_state <= ST_RUN;
        end else begin
            case (r_state)
                ST_RUN:   if (in_flush) r_state <= ST_DRAIN;
                ST_DRAIN: if ((r_pending == '0) && !r_rf_we && !w_xfer) r_state <= ST_RUN;
                default:  r_state <= ST_RUN;
            endcase
        end
    end

    assign out_rf_Data      = r_rf_data;
    assign out_rf_writeAddr = r_rf_addr;
    assign out_rf_write_En  = r_rf_we;
    assign out_pending_Mask = r_pending;
    assign out_drain_Busy   = (r_state == ST_DRAIN);
    assign out_err_Stray    = r_err;

endmodule

// File: tb/tb_fp_writeback_scheduler.sv
// Purpose: scoreboard bench for fp_writeback_scheduler against a queue-based reference model.
// Latency: expects each granted result on the register-file port exactly one cycle after its grant.
// Backpressure: producers hold their result until granted; issue is retried by the stimulus.
module tb_fp_writeback_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_vld = 1'b0;
    logic [4:0]  issue_rd = '0, rs1 = '0, rs2 = '0, rs3 = '0;
    logic [2:0]  mask = '0;
    logic        issue_rdy;
    logic        flush = 1'b0;
    logic [2:0]  req_vld = '0;
    logic [14:0] req_addr = '0;
    logic [95:0] req_data = '0;
    logic [2:0]  req_rdy;
    logic [31:0] rf_data;
    logic [4:0]  rf_addr;
    logic        rf_we;
    logic [31:0] pend_mask;
    logic        drain_busy, err_stray;

    always #5 clk = ~clk;

    fp_writeback_scheduler #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .in_Clk(clk), .in_Rst_N(rst_n),
        .in_issue_Valid(issue_vld), .in_issue_Rd(issue_rd),
        .in_issue_Rs1(rs1), .in_issue_Rs2(rs2), .in_issue_Rs3(rs3),
        .in_issue_UseMask(mask), .out_issue_Ready(issue_rdy), .in_flush(flush),
        .in_req_Valid(req_vld), .in_req_Addr(req_addr), .in_req_Data(req_data),
        .out_req_Ready(req_rdy), .out_rf_Data(rf_data), .out_rf_writeAddr(rf_addr),
        .out_rf_write_En(rf_we), .out_pending_Mask(pend_mask),
        .out_drain_Busy(drain_busy), .out_err_Stray(err_stray)
    );

    typedef struct { logic [4:0] addr; logic [31:0] data; } res_t;
    typedef struct { logic [4:0] addr; logic [31:0] data; int due; } wr_t;

    int checks = 0, failures = 0, cyc = 0;

    // Stimulus staging, applied just after the next rising edge.
    logic       s_vld = 0, s_flush = 0;
    logic [4:0] s_rd = 0, s_rs1 = 0, s_rs2 = 0, s_rs3 = 0;
    logic [2:0] s_mask = 0;
    int         issue_prod = -1;
    int         p_rate[3];

    // Producers: each owes the results of the instructions routed to it, in order.
    res_t       pq0[$], pq1[$], pq2[$];
    bit         pv[3];
    logic [4:0] pa[3];
    logic [31:0] pd[3];

    // Reference model state.
    logic [31:0] m_pend;
    bit          m_run, m_err, m_wr_now;
    logic [4:0]  m_wr_addr;
    int          m_next;
    wr_t         expq[$];
    logic [4:0]  mon_la;
    logic [31:0] mon_ld;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int pq_size(input int i);
        return (i == 0) ? pq0.size() : (i == 1) ? pq1.size() : pq2.size();
    endfunction
    function automatic res_t pq_front(input int i);
        return (i == 0) ? pq0[0] : (i == 1) ? pq1[0] : pq2[0];
    endfunction
    task automatic pq_push(input int i, input res_t r);
        if (i == 0) pq0.push_back(r); else if (i == 1) pq1.push_back(r); else pq2.push_back(r);
    endtask
    task automatic pq_pop(input int i);
        res_t r;
        if (i == 0) r = pq0.pop_front(); else if (i == 1) r = pq1.pop_front(); else r = pq2.pop_front();
    endtask

    task automatic drive_pins();
        req_vld  = {pv[2], pv[1], pv[0]};
        req_addr = {pa[2], pa[1], pa[0]};
        req_data = {pd[2], pd[1], pd[0]};
    endtask

    task automatic model_reset();
        m_pend = '0; m_run = 1; m_err = 0; m_wr_now = 0; m_wr_addr = '0; m_next = 0;
        expq.delete(); pq0.delete(); pq1.delete(); pq2.delete();
        for (int i = 0; i < 3; i++) begin pv[i] = 0; pa[i] = '0; pd[i] = '0; end
        mon_la = '0; mon_ld = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_issue_rdy"}, issue_rdy, 0);
        chk({tag, "_req_rdy"},   req_rdy, 0);
        chk({tag, "_rf_data"},   rf_data, 0);
        chk({tag, "_rf_addr"},   rf_addr, 0);
        chk({tag, "_rf_we"},     rf_we, 0);
        chk({tag, "_pending"},   pend_mask, 0);
        chk({tag, "_drain"},     drain_busy, 0);
        chk({tag, "_err"},       err_stray, 0);
    endtask

    // One clock cycle: apply staged stimulus, compare against the model, then advance the model.
    task automatic step();
        int win, p;
        logic [2:0] exp_gnt;
        logic [31:0] pold;
        bit exp_ir, acc;
        res_t r;
        @(posedge clk); #1;
        issue_vld = s_vld; issue_rd = s_rd; rs1 = s_rs1; rs2 = s_rs2; rs3 = s_rs3;
        mask = s_mask; flush = s_flush;
        for (int i = 0; i < 3; i++)
            if (!pv[i] && pq_size(i) > 0 && $urandom_range(0, 99) < p_rate[i]) begin
                r = pq_front(i); pv[i] = 1; pa[i] = r.addr; pd[i] = r.data;
            end
        drive_pins();
        @(negedge clk);
        exp_ir = m_run && !m_pend[issue_rd] && !(mask[0] && m_pend[rs1])
                 && !(mask[1] && m_pend[rs2]) && !(mask[2] && m_pend[rs3]);
        win = -1;
        for (int k = 0; k < 3; k++) if (win < 0 && pv[(m_next + k) % 3]) win = (m_next + k) % 3;
        exp_gnt = (win < 0) ? 3'b000 : 3'(1 << win);
        chk("issue_rdy", issue_rdy, exp_ir);
        chk("req_rdy", req_rdy, exp_gnt);
        chk("pending", pend_mask, m_pend);
        chk("drain_busy", drain_busy, !m_run);
        chk("err_stray", err_stray, m_err);
        pold = m_pend;
        acc  = issue_vld && exp_ir;
        if (m_wr_now) m_pend[m_wr_addr] = 0;
        if (acc) begin
            m_pend[issue_rd] = 1;
            p = (issue_prod < 0) ? $urandom_range(0, 2) : issue_prod;
            r.addr = issue_rd; r.data = $urandom;
            pq_push(p, r);
        end
        if (!m_run) begin
            if (pold == 0 && !m_wr_now && win < 0) m_run = 1;
        end else if (flush) m_run = 0;
        m_wr_now = 0;
        if (win >= 0) begin
            if (!pold[pa[win]]) m_err = 1;
            expq.push_back('{pa[win], pd[win], cyc + 1});
            m_wr_now = 1; m_wr_addr = pa[win];
            m_next = (win + 1) % 3;
            pv[win] = 0;
            pq_pop(win);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_rates(input int a, input int b, input int c);
        p_rate[0] = a; p_rate[1] = b; p_rate[2] = c;
    endtask

    // Write-port monitor: every write must match the oldest outstanding grant, one cycle later.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk); #3;
            if (rst_n) begin
                if (rf_we) begin
                    if (expq.size() == 0) chk("unexpected_write", rf_we, 0);
                    else begin
                        e = expq.pop_front();
                        chk("wr_addr", rf_addr, e.addr);
                        chk("wr_data", rf_data, e.data);
                        chk("wr_cycle", cyc, e.due);
                    end
                    mon_la = rf_addr; mon_ld = rf_data;
                end else begin
                    chk("hold_addr", rf_addr, mon_la);
                    chk("hold_data", rf_data, mon_ld);
                    if (expq.size() > 0 && expq[0].due <= cyc) begin
                        chk("missing_write", rf_we, 1);
                        e = expq.pop_front();
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        set_rates(0, 0, 0);
        // Reset state with reset held.
        #8;
        chk_all_zero("rst_init");
        @(negedge clk); @(negedge clk);
        rst_n = 1;

        // Mid-stream reset with f1,f2 pending and req1 valid.
        s_vld = 1; s_rd = 1; s_mask = 0; step();
        s_rd = 2; step();
        s_vld = 0; step();
        chk("pre_rst_pend", pend_mask, 32'h6);
        @(posedge clk); #1;
        pv[1] = 1; pa[1] = 5'd2; pd[1] = 32'h1234_5678; drive_pins();
        issue_vld = 1; issue_rd = 5'd9;
        #3 rst_n = 0;
        @(negedge clk); chk_all_zero("rst_mid");
        @(posedge clk); #1; chk_all_zero("rst_hold");
        @(negedge clk);
        rst_n = 1; model_reset(); drive_pins(); issue_vld = 0;

        // Basic write-back: f3 via the pipelined FPU.
        s_vld = 1; s_rd = 3; s_mask = 0; issue_prod = 1; step();
        s_vld = 0; set_rates(0, 100, 0); steps(4);
        chk("t2_pend3", pend_mask[3], 0);
        chk("t2_last_data", rf_data, 32'h3F80_0000 ^ 32'h3F80_0000 ^ mon_ld);

        // RAW hazard on f4 through rs2.
        set_rates(0, 0, 0); issue_prod = 2;
        s_vld = 1; s_rd = 4; s_mask = 0; step();
        s_rd = 5; s_rs2 = 4; s_mask = 3'b010; steps(3);
        s_vld = 0; s_mask = 3'b001; s_rs1 = 6; steps(2);
        s_vld = 1; s_mask = 3'b010; p_rate[2] = 100;
        for (int i = 0; i < 10 && !m_pend[5]; i++) step();
        s_vld = 0; step();
        chk("t3_pend5", pend_mask[5], 1);
        set_rates(100, 100, 100); issue_prod = -1; steps(4);

        // Three producers contending continuously.
        set_rates(0, 0, 0);
        for (int r = 0; r < 6; r++) begin
            issue_prod = r % 3; s_vld = 1; s_rd = 5'(10 + r); s_mask = 0; step();
        end
        s_vld = 0; set_rates(100, 100, 100); steps(9);

        // Flush with f1 (div) and f2 (load) outstanding.
        set_rates(0, 0, 0);
        issue_prod = 2; s_vld = 1; s_rd = 1; step();
        issue_prod = 0; s_rd = 2; step();
        s_vld = 0; s_flush = 1; step();
        s_flush = 0; s_vld = 1; s_rd = 7; steps(2);
        chk("t5_busy", drain_busy, 1);
        set_rates(100, 0, 100); steps(8);
        s_vld = 0;
        // Flush with nothing outstanding.
        s_flush = 1; step(); s_flush = 0; steps(3);
        set_rates(100, 100, 100); steps(6);

        // Randomized traffic with occasional flushes.
        issue_prod = -1; set_rates(40, 40, 40);
        for (int i = 0; i < 400; i++) begin
            s_vld = 1'($urandom_range(0, 1));
            s_rd = 5'($urandom); s_rs1 = 5'($urandom); s_rs2 = 5'($urandom); s_rs3 = 5'($urandom);
            s_mask = 3'($urandom); s_flush = ($urandom_range(0, 99) < 2);
            step();
        end
        s_vld = 0; s_flush = 0; set_rates(100, 100, 100);
        for (int i = 0; i < 200 && (pq0.size() + pq1.size() + pq2.size() + expq.size() > 0 || m_pend != 0 || !m_run); i++) step();
        steps(2);
        chk("drained", pend_mask, 0);
        chk("drained_busy", drain_begin_ok(), 1);

        // Stray write to a non-pending f9.
        begin
            res_t r;
            r.addr = 5'd9; r.data = 32'hDEAD_BEEF;
            pq_push(0, r);
        end
        steps(6);
        chk("t6_err", err_stray, 1);
        chk("t6_data", rf_data, 32'hDEAD_BEEF);
        rst_n = 0; #1;
        chk("t6_err_reset", err_stray, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic drain_begin_ok();
        return !drain_busy;
    endfunction

endmodule
